// File: rtl/up_down_count_checker.sv
// Monitors an up/down count stream: predicts each next value from the previous sample
// and the direction select, then reports lock, wrap, direction changes and step errors.
module up_down_count_checker #(
    parameter int WIDTH    = 4,
    parameter int ERR_W    = 8,
    parameter int LOCK_CNT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             sel,
    input  logic [WIDTH-1:0] count_in,
    input  logic             clr_err,
    output logic             locked,
    output logic             error,
    output logic             wrap,
    output logic             dir_change,
    output logic [ERR_W-1:0] err_count
);

    // state  | meaning
    // IDLE   | not sampling; the next enabled sample seeds the reference
    // ACQ    | counting consecutive correct steps toward lock
    // LOCKED | stream tracked; a bad step raises error and drops back to ACQ
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACQ    = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam int GW = $clog2(LOCK_CNT + 1);
    localparam logic [WIDTH-1:0] ONE_V  = WIDTH'(1);
    localparam logic [WIDTH-1:0] MAX_V  = {WIDTH{1'b1}};
    localparam logic [GW-1:0]    LOCK_V = GW'(LOCK_CNT);
    localparam logic [GW-1:0]    GOOD_1 = GW'(1);
    localparam logic [ERR_W-1:0] ERR_1  = ERR_W'(1);
    localparam logic [ERR_W-1:0] ERR_MX = {ERR_W{1'b1}};

    state_t           state_q, state_d;
    logic [WIDTH-1:0] ref_q, ref_d;
    logic [GW-1:0]    good_q, good_d;
    logic             prev_sel_q, prev_sel_d;
    logic             locked_q, locked_d;
    logic             error_q, error_d;
    logic             wrap_q, wrap_d;
    logic             dir_change_q, dir_change_d;
    logic [ERR_W-1:0] err_count_q, err_count_d;

    logic [WIDTH-1:0] expected;
    logic             match;
    logic             is_wrap;
    logic [GW-1:0]    good_inc;
    logic             err_inc;

    always_comb begin
        expected = sel ? (ref_q - ONE_V) : (ref_q + ONE_V);
        match    = (count_in == expected);
        is_wrap  = sel ? (ref_q == '0) : (ref_q == MAX_V);
        good_inc = good_q + GOOD_1;

        state_d      = state_q;
        ref_d        = ref_q;
        good_d       = good_q;
        prev_sel_d   = prev_sel_q;
        locked_d     = locked_q;
        error_d      = 1'b0;
        wrap_d       = 1'b0;
        dir_change_d = 1'b0;
        err_inc      = 1'b0;

        if (!enable) begin
            state_d  = IDLE;
            locked_d = 1'b0;
            good_d   = '0;
        end else begin
            prev_sel_d = sel;
            ref_d      = count_in;
            case (state_q)
                IDLE: begin
                    good_d   = '0;
                    locked_d = 1'b0;
                    state_d  = ACQ;
                end
                default: begin
                    // A direction flip is a resync of the reference, never a step error
                    if (sel != prev_sel_q) begin
                        dir_change_d = 1'b1;
                        good_d       = '0;
                        locked_d     = 1'b0;
                        state_d      = ACQ;
                    end else if (match) begin
                        wrap_d = is_wrap;
                        if (state_q != LOCKED) begin
                            good_d = good_inc;
                            if (good_inc >= LOCK_V) begin
                                state_d  = LOCKED;
                                locked_d = 1'b1;
                            end else begin
                                state_d = ACQ;
                            end
                        end
                    end else begin
                        good_d = '0;
                        if (state_q == LOCKED) begin
                            error_d  = 1'b1;
                            err_inc  = 1'b1;
                            locked_d = 1'b0;
                        end
                        state_d = ACQ;
                    end
                end
            endcase
        end

        if (clr_err)
            err_count_d = '0;
        else if (err_inc && (err_count_q != ERR_MX))
            err_count_d = err_count_q + ERR_1;
        else
            err_count_d = err_count_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            ref_q        <= '0;
            good_q       <= '0;
            prev_sel_q   <= 1'b0;
            locked_q     <= 1'b0;
            error_q      <= 1'b0;
            wrap_q       <= 1'b0;
            dir_change_q <= 1'b0;
            err_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            ref_q        <= ref_d;
            good_q       <= good_d;
            prev_sel_q   <= prev_sel_d;
            locked_q     <= locked_d;
            error_q      <= error_d;
            wrap_q       <= wrap_d;
            dir_change_q <= dir_change_d;
            err_count_q  <= err_count_d;
        end
    end

    assign locked     = locked_q;
    assign error      = error_q;
    assign wrap       = wrap_q;
    assign dir_change = dir_change_q;
    assign err_count  = err_count_q;

endmodule
